detector_event_builder: RTL and testbench

Parametrised single-clock successor to the per-block singles detector. It accepts pre-deserialised sample words for NT timing channels and NE energy channels (S samples per clock), and frames each event with a fine-resolution start time and per-channel saturating energy sums. Events are rejected when pile-up exceeds a length limit, and the block counts accepted, pile-up and dropped events. It sits between the SERDES capture stage and the block-to-module event arbiter.

---
 rtl/detector_event_builder.sv | 199 +++++++++++++++++++
 tb/tb_detector_event_builder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_event_builder.sv
// Event framer between SERDES capture and the event arbiter: bridges one-cycle gaps,
// captures a fine start time, sums per-channel energy and rejects pile-up.
//
// state  | meaning
// IDLE   | no event open; waits for activity while enable is high
// ACTIVE | event open; energy accumulates, start time captured once
// DRAIN  | pile-up aborted the event; waits for the channels to go quiet
module detector_event_builder #(
    parameter int NT        = 2,
    parameter int NE        = 8,
    parameter int S         = 8,
    parameter int EW        = 12,
    parameter int CW        = 17,
    parameter int DATA_BITS = 12 + NE*EW + CW + $clog2(S)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            block_id,
    input  logic [(NT+NE)*S-1:0]  samples,
    input  logic [CW-1:0]         counter,
    input  logic                  period_done,
    input  logic                  enable,
    input  logic [7:0]            max_len,
    input  logic                  data_ready,
    output logic                  data_valid,
    output logic [DATA_BITS-1:0]  data_out,
    output logic                  stall,
    output logic [47:0]           nsingles,
    output logic [31:0]           npileup,
    output logic [31:0]           ndropped
);

    localparam int FW  = $clog2(S);
    localparam int PCW = $clog2(S + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t state, state_nx;

    logic [S-1:0]       t_or;
    logic               t_rise;
    logic               ea, ta, hit, hit_q, act;
    logic [NE-1:0]      e_nz;
    logic [PCW-1:0]     pc [NE];
    logic [NT*S-1:0]    t_prev;
    logic [EW-1:0]      e_sum [NE];
    logic [NE*EW-1:0]   e_flat;
    logic [NE-1:0]      seen;
    logic               tcap, stall_arm;
    logic [CW+FW-1:0]   start_time;
    logic [7:0]         len;
    logic               open_ev, close_ev, timeout;
    logic               ev_valid, ack, load, drop, capture;
    logic               stall_set, stall_kill;

    function automatic logic [PCW-1:0] popcount(input logic [S-1:0] w);
        logic [PCW-1:0] c;
        c = '0;
        for (int b = 0; b < S; b++) c = c + PCW'(w[b]);
        return c;
    endfunction

    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [PCW-1:0] p);
        logic [EW:0] s;
        s = {1'b0, a} + (EW+1)'(p);
        return s[EW] ? '1 : s[EW-1:0];
    endfunction

    function automatic logic [FW-1:0] low_idx(input logic [S-1:0] w);
        logic [FW-1:0] r;
        r = '0;
        for (int b = S - 1; b >= 0; b--) if (w[b]) r = FW'(b);
        return r;
    endfunction

    // A timing channel qualifies for capture only on a bit that was low in its previous word.
    always_comb begin
        t_or   = '0;
        t_rise = 1'b0;
        for (int c = 0; c < NT; c++) begin
            t_or   = t_or | samples[c*S +: S];
            t_rise = t_rise | (|(samples[c*S +: S] & ~t_prev[c*S +: S]));
        end
    end

    always_comb begin
        e_nz   = '0;
        e_flat = '0;
        for (int i = 0; i < NE; i++) begin
            e_nz[i]             = |samples[(NT+i)*S +: S];
            pc[i]               = popcount(samples[(NT+i)*S +: S]);
            e_flat[i*EW +: EW]  = e_sum[i];
        end
    end

    assign ea  = |e_nz;
    assign ta  = |t_or;
    assign hit = ea | ta;
    assign act = hit | hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        open_ev  = 1'b0;
        close_ev = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (act && enable) begin
                    state_nx = ACTIVE;
                    open_ev  = 1'b1;
                end
            end
            ACTIVE: begin
                if (!act) begin
                    state_nx = IDLE;
                    close_ev = 1'b1;
                end else if ((max_len != 8'd0) && (len == max_len)) begin
                    state_nx = DRAIN;
                    timeout  = 1'b1;
                end
            end
            DRAIN: begin
                if (!act) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign capture    = (open_ev || (state == ACTIVE && !tcap)) && t_rise;
    assign ev_valid   = close_ev && tcap && (&seen);
    assign ack        = data_valid && data_ready;
    assign load       = ev_valid && (!data_valid || data_ready);
    assign drop       = ev_valid && !load;
    assign stall_set  = period_done && (state == ACTIVE) && tcap && (&seen);
    // Only the event that raised stall may withdraw it when it fails to produce a word.
    assign stall_kill = (stall_arm || stall_set) && (timeout || (close_ev && !ev_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q      <= 1'b0;
            t_prev     <= '0;
            seen       <= '0;
            len        <= '0;
            tcap       <= 1'b0;
            stall_arm  <= 1'b0;
            start_time <= '0;
            for (int i = 0; i < NE; i++) e_sum[i] <= '0;
        end else begin
            hit_q  <= hit;
            t_prev <= samples[NT*S-1:0];
            if (open_ev) begin
                for (int i = 0; i < NE; i++) e_sum[i] <= sat_add('0, pc[i]);
                seen      <= e_nz;
                len       <= 8'd1;
                tcap      <= 1'b0;
                stall_arm <= 1'b0;
            end else if (state == ACTIVE) begin
                for (int i = 0; i < NE; i++) e_sum[i] <= sat_add(e_sum[i], pc[i]);
                seen <= seen | e_nz;
                if (len != 8'hFF) len <= len + 8'd1;
            end
            if (capture) begin
                tcap       <= 1'b1;
                start_time <= {counter, low_idx(t_or)};
            end
            if (stall_set) stall_arm <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid <= 1'b0;
            data_out   <= '0;
            stall      <= 1'b0;
            nsingles   <= '0;
            npileup    <= '0;
            ndropped   <= '0;
        end else begin
            if (load) begin
                data_valid <= 1'b1;
                data_out   <= {5'b11111, 1'b1, block_id, e_flat, start_time};
                nsingles   <= nsingles + 48'd1;
            end else if (ack) begin
                data_valid <= 1'b0;
            end
            if (drop)    ndropped <= ndropped + 32'd1;
            if (timeout) npileup  <= npileup + 32'd1;
            if (stall_kill)     stall <= 1'b0;
            else if (stall_set) stall <= 1'b1;
            else if (ack)       stall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_detector_event_builder.sv
// Directed bench for detector_event_builder: default build plus a 4-bit energy build
// sharing the same stimulus to observe sum saturation.
module tb_detector_event_builder;

    logic        clk;
    logic        rst;
    logic [5:0]  block_id;
    logic [79:0] samples;
    logic [16:0] counter;
    logic        period_done;
    logic        enable;
    logic [7:0]  max_len;
    logic        data_ready;

    logic         data_valid, stall;
    logic [127:0] data_out;
    logic [47:0]  nsingles;
    logic [31:0]  npileup, ndropped;

    logic         data_valid4, stall4;
    logic [63:0]  data_out4;
    logic [47:0]  nsingles4;
    logic [31:0]  npileup4, ndropped4;

    int checks = 0;
    int errors = 0;

    detector_event_builder dut (
        .clk(clk), .rst(rst), .block_id(block_id), .samples(samples), .counter(counter),
        .period_done(period_done), .enable(enable), .max_len(max_len), .data_ready(data_ready),
        .data_valid(data_valid), .data_out(data_out), .stall(stall),
        .nsingles(nsingles), .npileup(npileup), .ndropped(ndropped)
    );

    detector_event_builder #(.EW(4)) dut4 (
        .clk(clk), .rst(rst), .block_id(block_id), .samples(samples), .counter(counter),
        .period_done(period_done), .enable(enable), .max_len(max_len), .data_ready(data_ready),
        .data_valid(data_valid4), .data_out(data_out4), .stall(stall4),
        .nsingles(nsingles4), .npileup(npileup4), .ndropped(ndropped4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   t0, t1, e, em;
        logic [16:0]  cnt;
        logic         rdy;
        logic         exp_dv;
        logic [47:0]  exp_ns;
        logic         chk_word;
        logic [127:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] word_of(input logic [5:0] bid, input logic [11:0] e,
                                             input logic [16:0] cnt, input logic [2:0] idx);
        return {5'b11111, 1'b1, bid, {8{e}}, cnt, idx};
    endfunction

    function automatic vec_t mk(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] e,
                                input logic [7:0] em, input logic [16:0] cnt, input logic rdy,
                                input logic dv, input logic [47:0] ns, input logic cw,
                                input logic [127:0] w);
        vec_t v;
        v.t0 = t0; v.t1 = t1; v.e = e; v.em = em; v.cnt = cnt; v.rdy = rdy;
        v.exp_dv = dv; v.exp_ns = ns; v.chk_word = cw; v.exp_word = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] e,
                         input logic [7:0] em, input logic [16:0] cnt);
        logic [79:0] s;
        s = '0;
        s[7:0]  = t0;
        s[15:8] = t1;
        for (int i = 0; i < 8; i++) if (em[i]) s[16 + i*8 +: 8] = e;
        samples = s;
        counter = cnt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            drive(8'h00, 8'h00, 8'h00, 8'h00, 17'd0);
            cyc();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; block_id = 6'h2A; samples = '0; counter = '0;
        period_done = 1'b0; enable = 1'b1; max_len = 8'd0; data_ready = 1'b0;

        // Default-width vectors: basic event, single-cycle gap, missing channel, multi-channel capture.
        vecs.push_back(mk(8'h10, 8'h00, 8'hFF, 8'hFF, 17'd100, 0, 0, 0, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd101, 0, 0, 0, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd102, 0, 0, 0, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd103, 0, 1, 1, 1, word_of(6'h2A, 12'd16, 17'd100, 3'd4)));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd104, 1, 0, 1, 0, '0));
        vecs.push_back(mk(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd200, 0, 0, 1, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd201, 0, 0, 1, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd202, 0, 0, 1, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd203, 0, 0, 1, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd204, 0, 1, 2, 1, word_of(6'h2A, 12'd16, 17'd200, 3'd0)));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd205, 1, 0, 2, 0, '0));
        vecs.push_back(mk(8'h04, 8'h00, 8'hFF, 8'hDF, 17'd300, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'hFF, 8'hDF, 17'd301, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd302, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd303, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd304, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'hC0, 8'h30, 8'h0F, 8'hFF, 17'd400, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd401, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd402, 0, 0, 2, 0, '0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd403, 0, 1, 3, 1, word_of(6'h2A, 12'd12, 17'd400, 3'd4)));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 17'd404, 1, 0, 3, 0, '0));

        repeat (3) cyc();
        chk("reset data_valid", data_valid, 0);
        chk("reset data_out", data_out, 0);
        chk("reset stall", stall, 0);
        chk("reset nsingles", nsingles, 0);
        chk("reset npileup", npileup, 0);
        chk("reset ndropped", ndropped, 0);
        rst = 1'b1;
        cyc();

        foreach (vecs[i]) begin
            drive(vecs[i].t0, vecs[i].t1, vecs[i].e, vecs[i].em, vecs[i].cnt);
            data_ready = vecs[i].rdy;
            cyc();
            chk($sformatf("row%0d data_valid", i), data_valid, vecs[i].exp_dv);
            chk($sformatf("row%0d nsingles", i), nsingles, vecs[i].exp_ns);
            if (vecs[i].chk_word) chk($sformatf("row%0d data_out", i), data_out, vecs[i].exp_word);
        end
        data_ready = 1'b0;
        chk("table npileup", npileup, 0);
        chk("table ndropped", ndropped, 0);

        // Pile-up: limit 4 aborts a 10-cycle burst on the 5th cycle.
        max_len = 8'd4;
        for (int k = 0; k < 10; k++) begin
            drive((k == 0) ? 8'h01 : 8'h00, 8'h00, 8'hFF, 8'hFF, 17'd500);
            cyc();
            chk($sformatf("pileup cyc%0d data_valid", k), data_valid, 0);
            if (k == 3) chk("pileup before limit", npileup, 0);
            if (k == 4) chk("pileup at limit", npileup, 1);
        end
        quiet(2);
        chk("pileup end data_valid", data_valid, 0);
        chk("pileup end nsingles", nsingles, 3);
        chk("pileup end npileup", npileup, 1);

        max_len = 8'd0;
        for (int k = 0; k < 10; k++) begin
            drive((k == 0) ? 8'h01 : 8'h00, 8'h00, 8'hFF, 8'hFF, 17'd510);
            cyc();
        end
        quiet(1);
        chk("nolimit k+2 data_valid", data_valid, 0);
        quiet(1);
        chk("nolimit data_valid", data_valid, 1);
        chk("nolimit nsingles", nsingles, 4);
        chk("nolimit data_out", data_out, word_of(6'h2A, 12'd80, 17'd510, 3'd0));
        chk("nolimit npileup", npileup, 1);
        data_ready = 1'b1; quiet(1); data_ready = 1'b0;

        // Backpressure with a period boundary during the second event.
        drive(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd600); cyc();
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd601); cyc();
        quiet(2);
        chk("bp first data_valid", data_valid, 1);
        chk("bp first nsingles", nsingles, 5);
        drive(8'h02, 8'h00, 8'hFF, 8'hFF, 17'd700); cyc();
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd701); cyc();
        chk("bp stall before boundary", stall, 0);
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd702); period_done = 1'b1; cyc();
        period_done = 1'b0;
        chk("bp stall set", stall, 1);
        quiet(2);
        chk("bp ndropped", ndropped, 1);
        chk("bp nsingles held", nsingles, 5);
        chk("bp data_valid held", data_valid, 1);
        chk("bp data_out held", data_out, word_of(6'h2A, 12'd16, 17'd600, 3'd0));
        quiet(1);
        chk("bp stall held", stall, 1);
        data_ready = 1'b1; quiet(1); data_ready = 1'b0;
        chk("bp ack data_valid", data_valid, 0);
        chk("bp ack stall", stall, 0);

        // enable low blocks opening; dropping it mid-event lets the event finish.
        enable = 1'b0;
        drive(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd750); cyc();
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd751); cyc();
        quiet(2);
        chk("enable low data_valid", data_valid, 0);
        chk("enable low nsingles", nsingles, 5);
        enable = 1'b1;
        drive(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd800); cyc();
        enable = 1'b0;
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd801); cyc();
        quiet(2);
        chk("enable drop data_valid", data_valid, 1);
        chk("enable drop nsingles", nsingles, 6);
        chk("enable drop data_out", data_out, word_of(6'h2A, 12'd16, 17'd800, 3'd0));
        data_ready = 1'b1; quiet(1); data_ready = 1'b0;
        enable = 1'b1;

        // Saturation: 3 cycles of 8 hits give 24, which clips to 15 in the 4-bit build.
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? 8'h01 : 8'h00, 8'h00, 8'hFF, 8'hFF, 17'd900);
            cyc();
        end
        quiet(2);
        chk("sat wide data_out", data_out, word_of(6'h2A, 12'd24, 17'd900, 3'd0));
        chk("sat wide nsingles", nsingles, 7);
        chk("sat narrow data_valid", data_valid4, 1);
        chk("sat narrow data_out", data_out4, {5'b11111, 1'b1, 6'h2A, {8{4'hF}}, 17'd900, 3'd0});
        chk("sat narrow nsingles", nsingles4, 7);

        // Reset mid-event with a word pending.
        drive(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd950); cyc();
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd951);
        #3 rst = 1'b0;
        #1;
        chk("midrst data_valid", data_valid, 0);
        chk("midrst data_out", data_out, 0);
        chk("midrst stall", stall, 0);
        chk("midrst nsingles", nsingles, 0);
        chk("midrst npileup", npileup, 0);
        chk("midrst ndropped", ndropped, 0);
        chk("midrst narrow data_out", data_out4, 0);
        quiet(1);
        rst = 1'b1;
        quiet(1);
        drive(8'h01, 8'h00, 8'hFF, 8'hFF, 17'd1000); cyc();
        drive(8'h00, 8'h00, 8'hFF, 8'hFF, 17'd1001); cyc();
        quiet(1);
        chk("post rst k+2 data_valid", data_valid, 0);
        quiet(1);
        chk("post rst data_valid", data_valid, 1);
        chk("post rst nsingles", nsingles, 1);
        chk("post rst data_out", data_out, word_of(6'h2A, 12'd16, 17'd1000, 3'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
